// File: rtl/regfile_wb_arbiter_pkg.sv
// Types and helpers shared by the write-back arbiter and its sub-modules.
package regfile_wb_arbiter_pkg;

`include "constants.svh"

    typedef logic [REG_ADDR_SIZE-1:0] reg_addr_t;
    typedef logic [REG_SIZE-1:0]      reg_data_t;

    // One-hot mask selecting a single register in the busy vector.
    function automatic logic [NUM_REGS-1:0] reg_mask(input reg_addr_t addr);
        logic [NUM_REGS-1:0] m;
        m       = '0;
        m[addr] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/constants.svh
// Shared widths and write-back source indices for the register file write port.
`ifndef CONSTANTS_SVH
`define CONSTANTS_SVH

localparam int unsigned REG_SIZE      = 32;
localparam int unsigned REG_ADDR_SIZE = 5;
localparam int unsigned NUM_REGS      = 32;

// Write-back source indices; also the bit positions in the arbiter req/grant vectors.
localparam int unsigned WB_SRC_ALU = 0;
localparam int unsigned WB_SRC_MEM = 1;

`endif

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: on a tie, the requester not granted last wins.
module rr_arbiter2
    import regfile_wb_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    input  logic       advance_i,
    output logic [1:0] grant_o
);

    // 1 means src1 (MEM) was granted last; reset so src0 wins the first tie.
    logic last_q;

    // Grant is purely a function of the requests and the last-grant flop.
    always_comb begin
        grant_o = req_i;
        if (req_i == 2'b11) begin
            grant_o = last_q ? 2'b01 : 2'b10;
        end
    end

    // Remember the winner only when a grant actually turns into a transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 1'b1;
        end else if (advance_i && (grant_o != 2'b00)) begin
            last_q <= grant_o[WB_SRC_MEM];
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter and busy scoreboard in front of the register file write port.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     Src0Valid,
    input  logic [REG_ADDR_SIZE-1:0] Src0Reg,
    input  logic [REG_SIZE-1:0]      Src0Data,
    output logic                     Src0Ready,
    input  logic                     Src1Valid,
    input  logic [REG_ADDR_SIZE-1:0] Src1Reg,
    input  logic [REG_SIZE-1:0]      Src1Data,
    output logic                     Src1Ready,
    input  logic                     AllocValid,
    input  logic [REG_ADDR_SIZE-1:0] AllocReg,
    output logic [NUM_REGS-1:0]      Busy,
    output logic                     WriteEnable,
    output logic [REG_ADDR_SIZE-1:0] WriteReg,
    output logic [REG_SIZE-1:0]      WriteData
);

    logic [1:0]          req;
    logic [1:0]          grant;
    logic                transfer;
    reg_addr_t           win_reg;
    reg_data_t           win_data;

    logic                we_d, we_q;
    reg_addr_t           wreg_d, wreg_q;
    reg_data_t           wdata_d, wdata_q;
    logic [NUM_REGS-1:0] busy_d, busy_q;

    assign req[WB_SRC_ALU] = Src0Valid;
    assign req[WB_SRC_MEM] = Src1Valid;

    rr_arbiter2 u_arb (
        .clk       (clk),
        .rst       (rst),
        .req_i     (req),
        .advance_i (transfer),
        .grant_o   (grant)
    );

    // A grant is only ever given to a valid source, so any grant is a transfer.
    assign transfer  = |grant;
    assign Src0Ready = grant[WB_SRC_ALU];
    assign Src1Ready = grant[WB_SRC_MEM];

    // Select the winner's destination and data, and build the next write command.
    always_comb begin
        win_reg  = grant[WB_SRC_MEM] ? Src1Reg  : Src0Reg;
        win_data = grant[WB_SRC_MEM] ? Src1Data : Src0Data;
        we_d     = 1'b0;
        wreg_d   = wreg_q;
        wdata_d  = wdata_q;
        if (transfer) begin
            // Writes to r0 are accepted but never reach the register file.
            we_d    = (win_reg != '0);
            wreg_d  = win_reg;
            wdata_d = win_data;
        end
    end

    // Scoreboard: clear on a committing write, then set on alloc so a new producer wins.
    always_comb begin
        busy_d = busy_q;
        if (we_q) begin
            busy_d = busy_d & ~reg_mask(wreg_q);
        end
        if (AllocValid && (AllocReg != '0)) begin
            busy_d = busy_d | reg_mask(AllocReg);
        end
    end

    // Registered write command and busy vector; reset drops any pending write.
    always_ff @(posedge clk) begin
        if (rst) begin
            we_q    <= 1'b0;
            wreg_q  <= '0;
            wdata_q <= '0;
            busy_q  <= '0;
        end else begin
            we_q    <= we_d;
            wreg_q  <= wreg_d;
            wdata_q <= wdata_d;
            busy_q  <= busy_d;
        end
    end

    assign WriteEnable = we_q;
    assign WriteReg    = wreg_q;
    assign WriteData   = wdata_q;
    assign Busy        = busy_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench: directed vector table, hand-written reset sequence, random vs model.
module tb_regfile_wb_arbiter;
    import regfile_wb_arbiter_pkg::*;

    logic                     clk;
    logic                     rst;
    logic                     Src0Valid, Src1Valid, AllocValid;
    logic [REG_ADDR_SIZE-1:0] Src0Reg, Src1Reg, AllocReg;
    logic [REG_SIZE-1:0]      Src0Data, Src1Data;
    logic                     Src0Ready, Src1Ready;
    logic [NUM_REGS-1:0]      Busy;
    logic                     WriteEnable;
    logic [REG_ADDR_SIZE-1:0] WriteReg;
    logic [REG_SIZE-1:0]      WriteData;

    int total = 0;
    int bad   = 0;

    regfile_wb_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .Src0Valid   (Src0Valid),
        .Src0Reg     (Src0Reg),
        .Src0Data    (Src0Data),
        .Src0Ready   (Src0Ready),
        .Src1Valid   (Src1Valid),
        .Src1Reg     (Src1Reg),
        .Src1Data    (Src1Data),
        .Src1Ready   (Src1Ready),
        .AllocValid  (AllocValid),
        .AllocReg    (AllocReg),
        .Busy        (Busy),
        .WriteEnable (WriteEnable),
        .WriteReg    (WriteReg),
        .WriteData   (WriteData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        v0;
        logic [4:0]  r0;
        logic [31:0] d0;
        logic        v1;
        logic [4:0]  r1;
        logic [31:0] d1;
        logic        av;
        logic [4:0]  ar;
        logic        rdy0;
        logic        rdy1;
        logic        we;
        logic [4:0]  wreg;
        logic [31:0] wdata;
        logic [31:0] busy;
    } vec_t;

    vec_t tbl[14];

    function automatic vec_t mk(
        input logic v0, input logic [4:0] r0, input logic [31:0] d0,
        input logic v1, input logic [4:0] r1, input logic [31:0] d1,
        input logic av, input logic [4:0] ar,
        input logic rdy0, input logic rdy1, input logic we,
        input logic [4:0] wreg, input logic [31:0] wdata, input logic [31:0] busy);
        vec_t v;
        v.v0 = v0; v.r0 = r0; v.d0 = d0;
        v.v1 = v1; v.r1 = r1; v.d1 = d1;
        v.av = av; v.ar = ar;
        v.rdy0 = rdy0; v.rdy1 = rdy1; v.we = we;
        v.wreg = wreg; v.wdata = wdata; v.busy = busy;
        return v;
    endfunction

    // ---------------- behavioural reference model ----------------
    int                  m_last  = 1;   // index of last granted source
    logic                m_we    = 1'b0;
    logic [4:0]          m_wreg  = '0;
    logic [31:0]         m_wdata = '0;
    logic [NUM_REGS-1:0] m_busy  = '0;

    // One clock with the currently driven inputs; returns the granted source (-1 if none).
    task automatic model_cycle(output int g);
        logic [4:0]  src_reg [2];
        logic [31:0] src_dat [2];
        src_reg[0] = Src0Reg;  src_reg[1] = Src1Reg;
        src_dat[0] = Src0Data; src_dat[1] = Src1Data;
        g = -1;
        if (Src0Valid && Src1Valid) g = 1 - m_last;
        else if (Src0Valid)         g = 0;
        else if (Src1Valid)         g = 1;
        @(negedge clk);
        if (!rst) begin
            check("src0_ready", 32'(Src0Ready), 32'(g == 0));
            check("src1_ready", 32'(Src1Ready), 32'(g == 1));
        end
        @(posedge clk);
        if (rst) begin
            m_last = 1; m_we = 1'b0; m_wreg = '0; m_wdata = '0; m_busy = '0;
            g = -1;
        end else begin
            if (m_we) m_busy[m_wreg] = 1'b0;
            if (AllocValid && AllocReg != 0) m_busy[AllocReg] = 1'b1;
            if (g >= 0) begin
                m_last  = g;
                m_we    = (src_reg[g] != 0);
                m_wreg  = src_reg[g];
                m_wdata = src_dat[g];
            end else begin
                m_we = 1'b0;
            end
        end
        #1;
        check("write_enable", 32'(WriteEnable), 32'(m_we));
        check("busy", 32'(Busy), 32'(m_busy));
        if (m_we || rst) begin
            check("write_reg", 32'(WriteReg), 32'(m_wreg));
            check("write_data", WriteData, m_wdata);
        end
    endtask

    task automatic idle_inputs();
        Src0Valid = 1'b0; Src0Reg = '0; Src0Data = '0;
        Src1Valid = 1'b0; Src1Reg = '0; Src1Data = '0;
        AllocValid = 1'b0; AllocReg = '0;
    endtask

    initial begin
        int g;
        rst = 1'b1;
        idle_inputs();
        @(posedge clk); #1;
        model_cycle(g);
        rst = 1'b0;

        // Directed table; starts from the reset state (last grant = src1).
        tbl[0]  = mk(0,0,0,           0,0,0,          0,0, 0,0, 0,0,0,           32'h0);
        tbl[1]  = mk(0,0,0,           0,0,0,          1,5, 0,0, 0,0,0,           32'h20);
        tbl[2]  = mk(1,5,32'hDEADBEEF,0,0,0,          0,0, 1,0, 1,5,32'hDEADBEEF,32'h20);
        tbl[3]  = mk(0,0,0,           0,0,0,          0,0, 0,0, 0,0,0,           32'h0);
        tbl[4]  = mk(0,0,0,           1,6,32'h66,     0,0, 0,1, 1,6,32'h66,      32'h0);
        tbl[5]  = mk(1,1,32'h11,      1,3,32'h33,     0,0, 1,0, 1,1,32'h11,      32'h0);
        tbl[6]  = mk(1,2,32'h22,      1,3,32'h33,     0,0, 0,1, 1,3,32'h33,      32'h0);
        tbl[7]  = mk(1,2,32'h22,      1,4,32'h44,     0,0, 1,0, 1,2,32'h22,      32'h0);
        tbl[8]  = mk(0,0,0,           1,4,32'h44,     0,0, 0,1, 1,4,32'h44,      32'h0);
        tbl[9]  = mk(1,0,32'hFFFFFFFF,0,0,0,          1,0, 1,0, 0,0,0,           32'h0);
        tbl[10] = mk(0,0,0,           0,0,0,          1,7, 0,0, 0,0,0,           32'h80);
        tbl[11] = mk(0,0,0,           1,7,32'h77,     0,0, 0,1, 1,7,32'h77,      32'h80);
        tbl[12] = mk(0,0,0,           0,0,0,          1,7, 0,0, 0,0,0,           32'h80);
        tbl[13] = mk(0,0,0,           0,0,0,          0,0, 0,0, 0,0,0,           32'h80);

        for (int i = 0; i < 14; i++) begin
            Src0Valid = tbl[i].v0; Src0Reg = tbl[i].r0; Src0Data = tbl[i].d0;
            Src1Valid = tbl[i].v1; Src1Reg = tbl[i].r1; Src1Data = tbl[i].d1;
            AllocValid = tbl[i].av; AllocReg = tbl[i].ar;
            @(negedge clk);
            check($sformatf("tbl%0d_rdy0", i), 32'(Src0Ready), 32'(tbl[i].rdy0));
            check($sformatf("tbl%0d_rdy1", i), 32'(Src1Ready), 32'(tbl[i].rdy1));
            @(posedge clk); #1;
            check($sformatf("tbl%0d_we", i), 32'(WriteEnable), 32'(tbl[i].we));
            check($sformatf("tbl%0d_busy", i), 32'(Busy), tbl[i].busy);
            if (tbl[i].we) begin
                check($sformatf("tbl%0d_wreg", i), 32'(WriteReg), 32'(tbl[i].wreg));
                check($sformatf("tbl%0d_wdata", i), WriteData, tbl[i].wdata);
            end
        end

        // Reset right after a transfer to r9 drops the write and clears busy.
        idle_inputs();
        rst = 1'b1;
        model_cycle(g);
        rst = 1'b0;
        AllocValid = 1'b1; AllocReg = 5'd9;
        model_cycle(g);
        idle_inputs();
        Src1Valid = 1'b1; Src1Reg = 5'd9; Src1Data = 32'h9999_0009;
        model_cycle(g);
        idle_inputs();
        rst = 1'b1;
        model_cycle(g);
        check("rst_drop_we", 32'(WriteEnable), 32'h0);
        check("rst_busy_clear", 32'(Busy), 32'h0);
        rst = 1'b0;
        Src0Valid = 1'b1; Src0Reg = 5'd10; Src0Data = 32'hA;
        Src1Valid = 1'b1; Src1Reg = 5'd11; Src1Data = 32'hB;
        @(negedge clk);
        check("rst_tie_src0", 32'(Src0Ready), 32'h1);
        @(posedge clk); #1;
        idle_inputs();
        rst = 1'b1;
        model_cycle(g);
        rst = 1'b0;

        // Random traffic; sources hold their item until transferred.
        for (int c = 0; c < 400; c++) begin
            rst        = ($urandom_range(0, 63) == 0);
            AllocValid = ($urandom_range(0, 1) == 1);
            AllocReg   = 5'($urandom_range(0, 31));
            model_cycle(g);
            if (!rst) begin
                if (!Src0Valid || g == 0) begin
                    Src0Valid = ($urandom_range(0, 3) != 0);
                    Src0Reg   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                    Src0Data  = $urandom;
                end
                if (!Src1Valid || g == 1) begin
                    Src1Valid = ($urandom_range(0, 3) != 0);
                    Src1Reg   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                    Src1Data  = $urandom;
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
